jt12_wr_sched: RTL

- Write scheduler between the CPU bus interface and the operator/channel register file.
- Accepts YM-style address/data bus writes and buffers them in a small FIFO.
- Decodes each entry into the register file's din/ch/op/up_* controls and holds each strobe for exactly one full slot round, so every time-multiplexed slot sees the update once.
- Sequences writes one at a time and reports busy/overflow back to the bus.

---
 rtl/jt12_wr_sched.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jt12_wr_sched.sv
// Write scheduler: buffers CPU bus writes and replays each one to the register
// file with a strobe held for a full slot round. Define JT12_WR_COALESCE_EN to merge repeated writes.
module jt12_wr_sched #(
  parameter int NUM_CH     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cpu_we,
  input  logic [1:0] cpu_a,
  input  logic [7:0] cpu_din,
  output logic       busy,
  output logic       full,
  output logic       ovf,
  output logic [7:0] din,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic       up_keyon,
  output logic       up_alg,
  output logic       up_fnumlo,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks_ar,
  output logic       up_amen_dr,
  output logic       up_sr,
  output logic       up_sl_rr,
  output logic       up_ssgeg,
  output logic [5:0] latch_fnum
);

  localparam int HOLD   = 4 * NUM_CH;
  localparam int CNT_W  = $clog2(24);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  HOLD_LD = CNT_W'(HOLD - 1);

  localparam int S_SSGEG   = 0;
  localparam int S_SL_RR   = 1;
  localparam int S_SR      = 2;
  localparam int S_AMEN_DR = 3;
  localparam int S_KS_AR   = 4;
  localparam int S_TL      = 5;
  localparam int S_DT1     = 6;
  localparam int S_PMS     = 7;
  localparam int S_FNUMLO  = 8;
  localparam int S_ALG     = 9;
  localparam int S_KEYON   = 10;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [10:0]        strb_reg, strb_next;
  logic [7:0]         din_reg, din_next;
  logic [2:0]         ch_reg, ch_next;
  logic [1:0]         op_reg, op_next;
  logic [5:0]         latch_reg, latch_next;

  logic [7:0]         sel_reg;
  logic               sel_part_reg;
  logic               ovf_reg;

  logic [16:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, last_ptr;
  logic [CNT_FW-1:0]  count_reg;

  logic        data_wr, addr_wr, pop, push, merge, drop, full_w;
  logic [16:0] head;
  logic        head_part;
  logic [7:0]  head_addr, head_data;
  logic        part_ok;
  logic [10:0] strb_dec;
  logic [2:0]  ch_dec;
  logic        dec_hold, dec_fnum;

  assign data_wr  = cpu_we & cpu_a[0];
  assign addr_wr  = cpu_we & ~cpu_a[0];
  assign full_w   = (count_reg == DEPTH_C);
  assign pop      = (state_reg == ST_IDLE) && (count_reg != '0);
  assign last_ptr = wr_ptr_reg - PTR_W'(1);

`ifdef JT12_WR_COALESCE_EN
  // Merge only into an entry that stays in the FIFO this clk; key-on writes are events, never merged.
  assign merge = data_wr && (count_reg != '0) && !(pop && count_reg == CNT_FW'(1)) &&
                 (fifo_mem[last_ptr][16:8] == {sel_part_reg, sel_reg}) && (sel_reg != 8'h28);
`else
  assign merge = 1'b0;
`endif

  assign push = data_wr && !merge && (!full_w || pop);
  assign drop = data_wr && !merge && full_w && !pop;

  assign head      = fifo_mem[rd_ptr_reg];
  assign head_part = head[16];
  assign head_addr = head[15:8];
  assign head_data = head[7:0];
  assign part_ok   = (NUM_CH != 3) || !head_part;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {sel_part_reg, sel_reg, cpu_din};
    end else if (merge) begin
      fifo_mem[last_ptr][7:0] <= cpu_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg      <= '0;
      sel_part_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      if (addr_wr) begin
        sel_reg      <= cpu_din;
        sel_part_reg <= cpu_a[1];
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_FW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_FW'(1);
      end
      if (drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  // Address decode of the FIFO head into one strobe (or fnum latch / discard)
  always_comb begin
    strb_dec = '0;
    dec_fnum = 1'b0;
    ch_dec   = {head_part, head_addr[1:0]};
    if (part_ok) begin
      if (head_addr == 8'h28) begin
        strb_dec[S_KEYON] = 1'b1;
        ch_dec            = head_data[2:0];
      end else if (head_addr[1:0] != 2'd3) begin
        case (head_addr[7:4])
          4'h3: strb_dec[S_DT1]     = 1'b1;
          4'h4: strb_dec[S_TL]      = 1'b1;
          4'h5: strb_dec[S_KS_AR]   = 1'b1;
          4'h6: strb_dec[S_AMEN_DR] = 1'b1;
          4'h7: strb_dec[S_SR]      = 1'b1;
          4'h8: strb_dec[S_SL_RR]   = 1'b1;
          4'h9: strb_dec[S_SSGEG]   = 1'b1;
          4'hA: begin
            if (head_addr[3:2] == 2'd0) begin
              strb_dec[S_FNUMLO] = 1'b1;
            end else if (head_addr[3:2] == 2'd1) begin
              dec_fnum = 1'b1;
            end
          end
          4'hB: begin
            if (head_addr[3:2] == 2'd0) begin
              strb_dec[S_ALG] = 1'b1;
            end else if (head_addr[3:2] == 2'd1) begin
              strb_dec[S_PMS] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    dec_hold = |strb_dec;
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    strb_next     = strb_reg;
    din_next      = din_reg;
    ch_next       = ch_reg;
    op_next       = op_reg;
    latch_next    = latch_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pop) begin
          din_next  = head_data;
          ch_next   = ch_dec;
          op_next   = head_addr[3:2];
          strb_next = strb_dec;
          if (dec_fnum) begin
            latch_next = head_data[5:0];
          end
          if (dec_hold) begin
            state_next    = ST_HOLD;
            hold_cnt_next = HOLD_LD;
          end
        end
      end
      ST_HOLD: begin
        // Counter runs on slot advances so every slot of the round sees the strobe
        if (clk_en) begin
          if (hold_cnt_reg == '0) begin
            strb_next  = '0;
            state_next = ST_IDLE;
          end else begin
            hold_cnt_next = hold_cnt_reg - CNT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      strb_reg     <= '0;
      din_reg      <= '0;
      ch_reg       <= '0;
      op_reg       <= '0;
      latch_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      strb_reg     <= strb_next;
      din_reg      <= din_next;
      ch_reg       <= ch_next;
      op_reg       <= op_next;
      latch_reg    <= latch_next;
    end
  end

  assign busy       = (count_reg != '0) || (state_reg != ST_IDLE);
  assign full       = full_w;
  assign ovf        = ovf_reg;
  assign din        = din_reg;
  assign ch         = ch_reg;
  assign op         = op_reg;
  assign latch_fnum = latch_reg;

  assign up_keyon   = strb_reg[S_KEYON];
  assign up_alg     = strb_reg[S_ALG];
  assign up_fnumlo  = strb_reg[S_FNUMLO];
  assign up_pms     = strb_reg[S_PMS];
  assign up_dt1     = strb_reg[S_DT1];
  assign up_tl      = strb_reg[S_TL];
  assign up_ks_ar   = strb_reg[S_KS_AR];
  assign up_amen_dr = strb_reg[S_AMEN_DR];
  assign up_sr      = strb_reg[S_SR];
  assign up_sl_rr   = strb_reg[S_SL_RR];
  assign up_ssgeg   = strb_reg[S_SSGEG];

endmodule
